// File: rtl/wb_prefetch_burst_if.sv
// Control handshake plus the two Wishbone masters of the prefetch engine;
// master = the engine, slave = the memories and controller it talks to.
interface wb_prefetch_burst_if #(
  parameter int WIDTH = 32,
  parameter int ABITS = 12,
  parameter int BBITS = 10
);
  logic             begin_i;
  logic [ABITS-1:0] base_i;
  logic             ready_o;
  logic             busy_o;

  logic             a_cyc_o;
  logic             a_stb_o;
  logic             a_we_o;
  logic             a_bst_o;
  logic             a_ack_i;
  logic [ABITS-1:0] a_adr_o;
  logic [WIDTH-1:0] a_dat_i;
  logic [WIDTH-1:0] a_dat_o;

  logic             b_cyc_o;
  logic             b_stb_o;
  logic             b_we_o;
  logic             b_bst_o;
  logic             b_ack_i;
  logic [BBITS-1:0] b_adr_o;
  logic [WIDTH-1:0] b_dat_i;
  logic [WIDTH-1:0] b_dat_o;

  modport master (
    input  begin_i, base_i, a_ack_i, a_dat_i, b_ack_i, b_dat_i,
    output ready_o, busy_o,
    output a_cyc_o, a_stb_o, a_we_o, a_bst_o, a_adr_o, a_dat_o,
    output b_cyc_o, b_stb_o, b_we_o, b_bst_o, b_adr_o, b_dat_o
  );

  modport slave (
    output begin_i, base_i, a_ack_i, a_dat_i, b_ack_i, b_dat_i,
    input  ready_o, busy_o,
    input  a_cyc_o, a_stb_o, a_we_o, a_bst_o, a_adr_o, a_dat_o,
    input  b_cyc_o, b_stb_o, b_we_o, b_bst_o, b_adr_o, b_dat_o
  );
endinterface

// File: rtl/wb_prefetch_burst.sv
// Copies COUNT words from the a-port (bursts of <= BSIZE) through a 2^FBITS FIFO to the b-port; first strobe 2 cycles
// after begin_i. A bursts wait for FIFO space, b_ack_i stalls the drain. Optional abort_i via WB_PREFETCH_ABORT_EN.
module wb_prefetch_burst #(
  parameter int WIDTH = 32,
  parameter int ABITS = 12,
  parameter int BBITS = 10,
  parameter int COUNT = 16,
  parameter int BSIZE = 4,
  parameter int FBITS = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  wb_prefetch_burst_if.master bus
`ifdef WB_PREFETCH_ABORT_EN
  ,
  input logic                abort_i
`endif
);

  localparam int DEPTH = 1 << FBITS;
  localparam int RW    = ((BBITS > FBITS) ? BBITS : FBITS) + 1;
  localparam logic [RW-1:0]  BSIZE_R = RW'(BSIZE);
  localparam logic [RW-1:0]  COUNT_R = RW'(COUNT);
  localparam logic [RW-1:0]  DEPTH_R = RW'(DEPTH);
  localparam logic [RW-1:0]  ONE_R   = RW'(1);
  localparam logic [FBITS:0] ONE_F   = (FBITS+1)'(1);
  localparam logic [FBITS:0] TWO_F   = (FBITS+1)'(2);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t           state;
  logic             a_cyc;
  logic             a_stb;
  logic             a_bst;
  logic [ABITS-1:0] a_adr;
  logic [FBITS:0]   stb_left;
  logic [FBITS:0]   ack_left;
  logic [RW-1:0]    remaining;
  logic             b_cyc;
  logic [BBITS-1:0] b_adr;
  logic [FBITS-1:0] wr_ptr;
  logic [FBITS-1:0] rd_ptr;
  logic [FBITS:0]   used;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             push;
  logic             pop;
  logic             stop;
  logic             a_start;
  logic             b_start;
  logic [RW-1:0]    burst_n;
  logic [RW-1:0]    free_cnt;
  logic             unused_bdat;

  assign push     = a_cyc && bus.a_ack_i;
  assign pop      = b_cyc && bus.b_ack_i;
  assign burst_n  = (remaining < BSIZE_R) ? remaining : BSIZE_R;
  assign free_cnt = DEPTH_R - RW'(used);

`ifdef WB_PREFETCH_ABORT_EN
  logic aborting;
  assign stop = aborting || abort_i;
`else
  assign stop = 1'b0;
`endif

  // A burst is only launched when every word it will return already has a FIFO slot.
  assign a_start = (state == FILL) && !a_cyc && (remaining != '0) &&
                   (free_cnt >= burst_n) && !stop;
  assign b_start = ((state == FILL) || (state == DRAIN)) && !b_cyc &&
                   (used != '0) && !stop;

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= bus.a_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      a_cyc     <= 1'b0;
      a_stb     <= 1'b0;
      a_bst     <= 1'b0;
      a_adr     <= '0;
      stb_left  <= '0;
      ack_left  <= '0;
      remaining <= '0;
      b_cyc     <= 1'b0;
      b_adr     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
`ifdef WB_PREFETCH_ABORT_EN
      aborting  <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + FBITS'(1);
      if (pop)  rd_ptr <= rd_ptr + FBITS'(1);
      used <= used + (FBITS+1)'(push) - (FBITS+1)'(pop);

      // Strobes run back to back regardless of ack timing; acks are counted separately.
      if (a_stb) begin
        a_adr    <= a_adr + ABITS'(1);
        stb_left <= stb_left - ONE_F;
        a_stb    <= (stb_left != ONE_F);
        a_bst    <= (stb_left > TWO_F);
      end
      if (push) begin
        ack_left <= ack_left - ONE_F;
        if (ack_left == ONE_F) a_cyc <= 1'b0;
      end

      if (pop) begin
        b_cyc <= 1'b0;
        b_adr <= b_adr + BBITS'(1);
      end else if (b_start) begin
        b_cyc <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.begin_i) begin
            a_adr     <= bus.base_i;
            remaining <= COUNT_R;
            b_adr     <= '0;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (a_start) begin
            a_cyc     <= 1'b1;
            a_stb     <= 1'b1;
            a_bst     <= (burst_n > ONE_R);
            stb_left  <= burst_n[FBITS:0];
            ack_left  <= burst_n[FBITS:0];
            remaining <= remaining - burst_n;
          end else if ((remaining == '0) && !a_cyc) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((used == '0) && !b_cyc && !stop) begin
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef WB_PREFETCH_ABORT_EN
      if (abort_i && ((state == FILL) || (state == DRAIN))) begin
        aborting  <= 1'b1;
        remaining <= '0;
      end
      // Both masters are quiet: discard whatever the last burst left behind.
      if (aborting && !a_cyc && !b_cyc) begin
        aborting <= 1'b0;
        state    <= IDLE;
        busy     <= 1'b0;
        ready    <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        used     <= '0;
      end
`endif
    end
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = busy;
  assign bus.a_cyc_o = a_cyc;
  assign bus.a_stb_o = a_stb;
  assign bus.a_we_o  = 1'b0;
  assign bus.a_bst_o = a_bst;
  assign bus.a_adr_o = a_adr;
  assign bus.a_dat_o = '0;
  assign bus.b_cyc_o = b_cyc;
  assign bus.b_stb_o = b_cyc;
  assign bus.b_we_o  = b_cyc;
  assign bus.b_bst_o = 1'b0;
  assign bus.b_adr_o = b_adr;
  assign bus.b_dat_o = mem[rd_ptr];

  assign unused_bdat = ^bus.b_dat_i;

endmodule

// File: tb/tb_wb_prefetch_burst.sv
// Scoreboard bench: SRAM-backed a-slave, delayed-ack b-slave, negedge monitor against queued expectations.
module tb_wb_prefetch_burst;
  localparam int WIDTH = 32;
  localparam int ABITS = 12;
  localparam int BBITS = 10;
  localparam int COUNT = 17;
  localparam int BSIZE = 5;
  localparam int FBITS = 3;
  localparam int DEPTH = 1 << FBITS;
  localparam int AMOD  = 1 << ABITS;

  typedef struct {
    int               adr;
    logic [WIDTH-1:0] dat;
  } wexp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_prefetch_burst_if #(.WIDTH(WIDTH), .ABITS(ABITS), .BBITS(BBITS)) bus ();

`ifdef WB_PREFETCH_ABORT_EN
  logic abort;
`endif

  wb_prefetch_burst #(
    .WIDTH(WIDTH), .ABITS(ABITS), .BBITS(BBITS),
    .COUNT(COUNT), .BSIZE(BSIZE), .FBITS(FBITS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
`ifdef WB_PREFETCH_ABORT_EN
    ,
    .abort_i(abort)
`endif
  );

  logic [WIDTH-1:0] sram [AMOD];
  wexp_t exp_w[$];
  int    exp_aadr[$];
  int    exp_burst[$];

  int checks = 0;
  int errors = 0;
  bit zero_wait = 1'b1;
  int bdelay = 0;
  bit inject_ack = 1'b0;
  int b_words = 0;
  int ready_cnt = 0;
  int a_bursts = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    chk(name, {bus.a_cyc_o, bus.a_stb_o, bus.a_we_o, bus.a_bst_o,
               bus.b_cyc_o, bus.b_stb_o, bus.b_we_o, bus.b_bst_o,
               bus.ready_o, bus.busy_o, bus.a_adr_o, bus.b_adr_o}, 64'd0);
  endtask

  // Reference: word i comes from SRAM[(base+i) mod 2^ABITS] and lands at b address i.
  task automatic start_op(input int base);
    int rem;
    for (int i = 0; i < COUNT; i++) begin
      exp_aadr.push_back((base + i) % AMOD);
      exp_w.push_back('{adr: i, dat: sram[(base + i) % AMOD]});
    end
    rem = COUNT;
    while (rem > 0) begin
      exp_burst.push_back((rem < BSIZE) ? rem : BSIZE);
      rem -= (rem < BSIZE) ? rem : BSIZE;
    end
    bus.begin_i = 1'b1;
    bus.base_i  = ABITS'(base);
    cyc(1);
    bus.begin_i = 1'b0;
    bus.base_i  = ABITS'($urandom);
  endtask

  task automatic run_op(input int base, input bit extra_begins);
    int w0, r0;
    bit done;
    w0 = b_words;
    r0 = ready_cnt;
    done = 1'b0;
    start_op(base);
    for (int i = 0; i < 2000 && !done; i++) begin
      cyc(1);
      bus.begin_i = 1'b0;
      if (bus.ready_o) done = 1'b1;
      else if (extra_begins && bus.busy_o && ($urandom_range(0, 4) == 0)) begin
        bus.begin_i = 1'b1;
        bus.base_i  = ABITS'($urandom);
      end
    end
    bus.begin_i = 1'b0;
    chk("op_ready_seen", done, 1);
    cyc(2);
    chk("op_busy_fall", bus.busy_o, 0);
    chk("op_word_count", b_words - w0, COUNT);
    chk("op_ready_pulses", ready_cnt - r0, 1);
    chk("op_writes_left", exp_w.size(), 0);
    chk("op_strobes_left", exp_aadr.size(), 0);
  endtask

  // a-port slave: acks in strobe order after a random (or zero) lag.
  initial begin
    int pend[$];
    bus.a_ack_i = 1'b0;
    bus.a_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.a_cyc_o) pend.delete();
      if (bus.a_stb_o) pend.push_back(int'(bus.a_adr_o));
      if (inject_ack) begin
        bus.a_ack_i = 1'b1;
        bus.a_dat_i = $urandom;
      end else if (pend.size() > 0 && (zero_wait || $urandom_range(0, 2) == 0)) begin
        bus.a_ack_i = 1'b1;
        bus.a_dat_i = sram[pend.pop_front()];
      end else begin
        bus.a_ack_i = 1'b0;
        bus.a_dat_i = $urandom;
      end
    end
  end

  // b-port slave: acks each word after bdelay wait cycles.
  initial begin
    int w;
    w = 0;
    bus.b_ack_i = 1'b0;
    bus.b_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.b_dat_i = $urandom;
      if (inject_ack) bus.b_ack_i = 1'b1;
      else if (bus.b_stb_o) begin
        if (w >= bdelay) begin
          bus.b_ack_i = 1'b1;
          w = 0;
        end else begin
          bus.b_ack_i = 1'b0;
          w++;
        end
      end else begin
        bus.b_ack_i = 1'b0;
        w = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or completes a write.
  initial begin
    int pushes, pops, cur, occ_save, blen, cur_n, acks, n;
    bit prev_stb, prev_bst, prev_cyc, drop_due, gap_due;
    wexp_t e;
`ifdef WB_PREFETCH_ABORT_EN
    bit ab;
    ab = 1'b0;
`endif
    pushes = 0; pops = 0; occ_save = 0; blen = 0; cur_n = 0; acks = 0;
    prev_stb = 0; prev_bst = 0; prev_cyc = 0; drop_due = 0; gap_due = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_w.delete(); exp_aadr.delete(); exp_burst.delete();
        pushes = 0; pops = 0; occ_save = 0; blen = 0; acks = 0;
        prev_stb = 0; prev_bst = 0; prev_cyc = 0; drop_due = 0; gap_due = 0;
      end else begin
        cur = pushes - pops;
        if (drop_due) begin
          chk("a_cyc_drop_after_last_ack", bus.a_cyc_o, 0);
          drop_due = 0;
        end
        if (bus.a_cyc_o && !prev_cyc) begin
          a_bursts++;
          cur_n = (exp_burst.size() > 0) ? exp_burst[0] : 0;
          acks = 0;
          chk("a_stb_rises_with_cyc", bus.a_stb_o, 1);
          chk("a_burst_fifo_space", (occ_save + cur_n <= DEPTH), 1);
        end
        if (bus.a_stb_o) begin
          chk("a_cyc_during_stb", bus.a_cyc_o, 1);
          chk("a_strobe_expected", exp_aadr.size() > 0, 1);
          if (exp_aadr.size() > 0) chk("a_adr", bus.a_adr_o, exp_aadr.pop_front());
          chk("a_we_dat_zero", {bus.a_we_o, bus.a_dat_o}, 0);
          if (prev_stb) chk("a_bst_mid_burst", prev_bst, 1);
          blen++;
        end else if (prev_stb) begin
          chk("a_bst_last_strobe", prev_bst, 0);
          n = (exp_burst.size() > 0) ? exp_burst.pop_front() : 0;
          chk("a_burst_len", blen, n);
          blen = 0;
        end
        if (bus.a_cyc_o && bus.a_ack_i) begin
          pushes++;
          acks++;
          if (acks == cur_n) drop_due = 1;
        end
        if (gap_due) begin
          chk("b_stb_gap", bus.b_stb_o, 0);
          gap_due = 0;
        end
        if (bus.b_stb_o && bus.b_ack_i) begin
          chk("b_ctrl", {bus.b_cyc_o, bus.b_stb_o, bus.b_we_o, bus.b_bst_o}, 4'b1110);
          chk("b_write_expected", exp_w.size() > 0, 1);
          if (exp_w.size() > 0) begin
            e = exp_w.pop_front();
            chk("b_adr", bus.b_adr_o, e.adr);
            chk("b_dat", bus.b_dat_o, e.dat);
          end
          pops++;
          b_words++;
          gap_due = 1;
        end
        if (bus.ready_o) begin
          ready_cnt++;
          chk("ready_implies_busy", bus.busy_o, 1);
        end
`ifdef WB_PREFETCH_ABORT_EN
        if (abort && bus.busy_o) ab = 1'b1;
        if (ab && !bus.busy_o) begin
          ab = 1'b0;
          exp_w.delete(); exp_aadr.delete(); exp_burst.delete();
          pushes = 0; pops = 0; cur = 0;
        end
`endif
        occ_save = cur;
        prev_stb = bus.a_stb_o;
        prev_bst = bus.a_bst_o;
        prev_cyc = bus.a_cyc_o;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    bit hit;
    rst = 1'b1;
    bus.begin_i = 1'b0;
    bus.base_i  = '0;
`ifdef WB_PREFETCH_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < AMOD; i++) sram[i] = $urandom;

    cyc(3);
    check_idle("reset_outputs");
    rst = 1'b0;
    cyc(2);

    zero_wait = 1'b1; bdelay = 0;
    run_op(0, 1'b0);
    zero_wait = 1'b0; bdelay = 3;
    run_op($urandom_range(0, AMOD - 1), 1'b0);
    bdelay = $urandom_range(0, 3);
    run_op(AMOD - 2, 1'b0);
    zero_wait = 1'b1; bdelay = 1;
    run_op($urandom_range(0, AMOD - 1), 1'b1);
    for (int k = 0; k < 3; k++) begin
      zero_wait = 1'($urandom_range(0, 1));
      bdelay = $urandom_range(0, 4);
      run_op($urandom_range(0, AMOD - 1), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the second a burst.
    zero_wait = 1'b0; bdelay = 1;
    b0 = a_bursts;
    hit = 1'b0;
    start_op($urandom_range(0, AMOD - 1));
    for (int i = 0; i < 500 && !hit; i++) begin
      cyc(1);
      if (a_bursts >= b0 + 2) hit = 1'b1;
    end
    chk("second_burst_reached", hit, 1);
    chk("mid_reset_in_burst", bus.a_cyc_o, 1);
    rst = 1'b1;
    cyc(1);
    check_idle("mid_reset_outputs");
    rst = 1'b0;
    inject_ack = 1'b1;
    cyc(2);
    inject_ack = 1'b0;
    cyc(1);
    chk("stray_ack_ignored", {bus.busy_o, bus.a_cyc_o, bus.b_cyc_o, bus.b_adr_o}, 0);
    run_op($urandom_range(0, AMOD - 1), 1'b0);

`ifdef WB_PREFETCH_ABORT_EN
    begin
      int w0, r0;
      bit fell;
      zero_wait = 1'b0; bdelay = 2;
      w0 = b_words; r0 = ready_cnt;
      hit = 1'b0; fell = 1'b0;
      start_op($urandom_range(0, AMOD - 1));
      for (int i = 0; i < 1000 && !hit; i++) begin
        cyc(1);
        if (b_words - w0 >= 6) hit = 1'b1;
      end
      chk("abort_six_words", hit, 1);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      for (int i = 0; i < 500 && !fell; i++) begin
        cyc(1);
        if (!bus.busy_o) fell = 1'b1;
      end
      chk("abort_busy_fall", fell, 1);
      chk("abort_no_ready", ready_cnt - r0, 0);
      chk("abort_cyc_idle", {bus.a_cyc_o, bus.b_cyc_o}, 0);
      cyc(3);
      run_op($urandom_range(0, AMOD - 1), 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
